// File: rtl/bp_tournament_predictor_p.sv
// Tournament branch predictor: local two-level (LHT + local PHT), gshare global PHT and a
// GHR-indexed chooser, with a power-up table sweep and a saturating mispredict counter.
module bp_tournament_predictor_p #(
    parameter int bht_idx_width_p = 10,
    parameter int lhist_width_p   = 10,
    parameter int ghist_width_p   = 12,
    parameter int ctr_width_p     = 2,
    parameter int stat_width_p    = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       ready_o,
    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] idx_r_i,
    output logic                       predict_v_o,
    output logic                       predict_o,
    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] idx_w_i,
    input  logic                       taken_i,
    input  logic                       correct_i,
    output logic [stat_width_p-1:0]    mispred_cnt_o
);

    localparam int B  = bht_idx_width_p;
    localparam int L  = lhist_width_p;
    localparam int G  = ghist_width_p;
    localparam int C  = ctr_width_p;
    localparam int PW = (B > L) ? ((B > G) ? B : G) : ((L > G) ? L : G);

    localparam int LHT_D = 1 << B;
    localparam int LP_D  = 1 << L;
    localparam int GP_D  = 1 << G;

    localparam logic [C-1:0]  CTR_MAX  = '1;
    localparam logic [C-1:0]  CTR_WT   = {1'b1, {(C-1){1'b0}}};
    localparam logic [C-1:0]  CTR_WL   = {1'b0, {(C-1){1'b1}}};
    localparam logic [PW-1:0] PTR_LAST = '1;

    typedef enum logic {INIT_S, RUN_S} state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic                    ready_q;
    logic [G-1:0]            ghr_q;
    logic                    predict_v_q, predict_q;
    logic [stat_width_p-1:0] mispred_q;

    logic [L-1:0] lht_q  [LHT_D];
    logic [C-1:0] lpht_q [LP_D];
    logic [C-1:0] gpht_q [GP_D];
    logic [C-1:0] ch_q   [GP_D];

    function automatic logic [G-1:0] gshare_idx(input logic [G-1:0] ghr, input logic [B-1:0] idx);
        return ghr ^ G'(idx);
    endfunction

    function automatic logic [C-1:0] ctr_step(input logic [C-1:0] c, input logic up);
        if (up)
            return (c == CTR_MAX) ? c : c + 1'b1;
        else
            return (c == '0) ? c : c - 1'b1;
    endfunction

    // Ports are only honoured once the sweep has finished and reset is released.
    logic run_en, init_we;
    assign run_en  = ready_q & ~reset_i;
    assign init_we = (state_q == INIT_S) & ~reset_i;

    logic [L-1:0] lh_r, lh_w;
    logic [G-1:0] gidx_r, gidx_w;
    logic         lp_r, gp_r, sel_r, lp_w, gp_w;

    always_comb begin
        lh_r   = lht_q[idx_r_i];
        lp_r   = lpht_q[lh_r][C-1];
        gidx_r = gshare_idx(ghr_q, idx_r_i);
        gp_r   = gpht_q[gidx_r][C-1];
        sel_r  = ch_q[ghr_q][C-1];
        lh_w   = lht_q[idx_w_i];
        lp_w   = lpht_q[lh_w][C-1];
        gidx_w = gshare_idx(ghr_q, idx_w_i);
        gp_w   = gpht_q[gidx_w][C-1];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            INIT_S: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) state_d = RUN_S;
            end
            RUN_S:   state_d = RUN_S;
            default: state_d = INIT_S;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= INIT_S;
            ptr_q       <= '0;
            ready_q     <= 1'b0;
            ghr_q       <= '0;
            predict_v_q <= 1'b0;
            predict_q   <= 1'b0;
            mispred_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ready_q     <= (state_q == RUN_S);
            predict_v_q <= run_en & r_v_i;
            predict_q   <= run_en & r_v_i & (sel_r ? gp_r : lp_r);
            if (run_en & w_v_i) ghr_q <= {ghr_q[G-2:0], taken_i};
            if (run_en & w_v_i & ~correct_i & ~(&mispred_q)) mispred_q <= mispred_q + 1'b1;
        end
    end

    // Sweep pointer spans the deepest table; shallower tables skip out-of-range entries.
    always_ff @(posedge clk_i) begin
        if (init_we) begin
            if (int'(ptr_q) < LHT_D) lht_q[ptr_q[B-1:0]]  <= '0;
            if (int'(ptr_q) < LP_D)  lpht_q[ptr_q[L-1:0]] <= CTR_WT;
            if (int'(ptr_q) < GP_D) begin
                gpht_q[ptr_q[G-1:0]] <= CTR_WT;
                ch_q[ptr_q[G-1:0]]   <= CTR_WL;
            end
        end else if (run_en & w_v_i) begin
            lpht_q[lh_w]   <= ctr_step(lpht_q[lh_w], taken_i);
            gpht_q[gidx_w] <= ctr_step(gpht_q[gidx_w], taken_i);
            if (lp_w != gp_w) ch_q[ghr_q] <= ctr_step(ch_q[ghr_q], gp_w == taken_i);
            lht_q[idx_w_i] <= {lh_w[L-2:0], taken_i};
        end
    end

    assign ready_o       = ready_q;
    assign predict_v_o   = predict_v_q;
    assign predict_o     = predict_q;
    assign mispred_cnt_o = mispred_q;

endmodule

// File: tb/tb_bp_tournament_predictor_p.sv
// Scoreboarded bench for bp_tournament_predictor_p with small tables (idx 6, lhist 4, ghist 5)
// so the init sweep is 64 entries, and a 4-bit mispredict counter to reach saturation.
module tb_bp_tournament_predictor_p;

    localparam int B = 6;
    localparam int L = 4;
    localparam int G = 5;
    localparam int C = 2;
    localparam int S = 4;
    localparam int SWEEP_CYCLES = 65;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         ready_o;
    logic         r_v_i;
    logic [B-1:0] idx_r_i;
    logic         predict_v_o;
    logic         predict_o;
    logic         w_v_i;
    logic [B-1:0] idx_w_i;
    logic         taken_i;
    logic         correct_i;
    logic [S-1:0] mispred_cnt_o;

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];
    logic mon_en = 1'b0;
    logic mon_exp;

    bp_tournament_predictor_p #(
        .bht_idx_width_p(B), .lhist_width_p(L), .ghist_width_p(G),
        .ctr_width_p(C), .stat_width_p(S)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .ready_o(ready_o),
        .r_v_i(r_v_i), .idx_r_i(idx_r_i),
        .predict_v_o(predict_v_o), .predict_o(predict_o),
        .w_v_i(w_v_i), .idx_w_i(idx_w_i), .taken_i(taken_i), .correct_i(correct_i),
        .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every presented prediction is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (predict_v_o) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL predict_unexpected: predict_v_o=1 predict_o=%0b, required no prediction", predict_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (predict_o !== mon_exp) begin
                        errors++;
                        $display("FAIL predict_value: got %0b required %0b", predict_o, mon_exp);
                    end
                end
            end else if (predict_o !== 1'b0) begin
                errors++;
                $display("FAIL predict_idle: predict_o=%0b with predict_v_o=0, required 0", predict_o);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic op(input logic rd, input logic [B-1:0] ridx, input logic exp,
                      input logic wr, input logic [B-1:0] widx, input logic tk, input logic corr);
        r_v_i     = rd;
        idx_r_i   = ridx;
        w_v_i     = wr;
        idx_w_i   = widx;
        taken_i   = tk;
        correct_i = corr;
        if (rd) exp_q.push_back(exp);
        @(negedge clk);
        r_v_i = 1'b0;
        w_v_i = 1'b0;
    endtask

    task automatic rd(input logic [B-1:0] idx, input logic exp);
        op(1'b1, idx, exp, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [B-1:0] idx, input logic tk, input logic corr);
        op(1'b0, '0, 1'b0, 1'b1, idx, tk, corr);
    endtask

    // Counts posedges after reset release until ready_o is seen; bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (ready_o) break;
        end
        r_v_i = 1'b0;
        w_v_i = 1'b0;
    endtask

    int n;

    initial begin
        reset_i = 1'b1; r_v_i = 1'b0; w_v_i = 1'b0; idx_r_i = '0; idx_w_i = '0;
        taken_i = 1'b0; correct_i = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("reset_ready", ready_o, 0);
        chk("reset_predict_v", predict_v_o, 0);
        chk("reset_mispred", mispred_cnt_o, 0);

        // Sweep with both ports busy, then restart it mid-way.
        reset_i = 1'b0;
        r_v_i = 1'b1; idx_r_i = 6'd5; w_v_i = 1'b1; idx_w_i = 6'd5; taken_i = 1'b1; correct_i = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_sweep_not_ready", ready_o, 0);
        reset_i = 1'b1;
        @(negedge clk);
        chk("mid_sweep_reset_ready", ready_o, 0);
        reset_i = 1'b0;
        wait_ready(n);
        chk("sweep_cycles", n, SWEEP_CYCLES);
        @(negedge clk);
        chk("stat_ignored_in_init", mispred_cnt_o, 0);

        // Fresh tables: weakly-taken local chosen.
        rd(6'd5, 1'b1);

        // Train idx 5 not-taken; the first read shares the cycle with an update and sees old state.
        op(1'b1, 6'd5, 1'b1, 1'b1, 6'd5, 1'b0, 1'b0);
        wr(6'd5, 1'b0, 1'b0);
        wr(6'd5, 1'b0, 1'b0);
        rd(6'd5, 1'b0);
        chk("mispred_after_3", mispred_cnt_o, 3);

        // Alternating pattern on idx 9, starting taken, 64 updates ending not-taken.
        for (int k = 1; k <= 64; k++) wr(6'd9, (k % 2) == 1, 1'b1);
        rd(6'd9, 1'b1);
        wr(6'd9, 1'b1, 1'b1);
        rd(6'd9, 1'b0);
        chk("mispred_hold_correct", mispred_cnt_o, 3);

        // Mid-run reset clears GHR and stats and reruns the sweep.
        reset_i = 1'b1;
        @(negedge clk);
        chk("run_reset_mispred", mispred_cnt_o, 0);
        chk("run_reset_ready", ready_o, 0);
        reset_i = 1'b0;
        wait_ready(n);
        chk("resweep_cycles", n, SWEEP_CYCLES);
        @(negedge clk);

        // Give idx 20 history 1111 (GHR ends 01111).
        repeat (4) wr(6'd20, 1'b1, 1'b1);
        // Flush GHR to zero while driving gPHT[20] down to 0.
        wr(6'd27, 1'b0, 1'b1);
        wr(6'd10, 1'b0, 1'b1);
        repeat (3) wr(6'd40, 1'b0, 1'b1);
        rd(6'd20, 1'b1);
        rd(6'd5, 1'b0);
        // lp=1, gp=0, outcome 0 four times at GHR=0: chooser 1->2->3->3->3.
        repeat (4) wr(6'd20, 1'b0, 1'b1);
        rd(6'd5, 1'b1);
        rd(6'd20, 1'b0);
        chk("mispred_after_chooser", mispred_cnt_o, 0);

        // Stat saturation at 4 bits.
        for (int i = 0; i < 20; i++) begin
            wr(6'd40, 1'b0, 1'b0);
            if (i == 6) chk("mispred_7", mispred_cnt_o, 7);
            if (i == 14) chk("mispred_15", mispred_cnt_o, 15);
        end
        chk("mispred_saturated", mispred_cnt_o, 15);

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
